// File: rtl/row_hist_arbiter_pkg.sv
// Shared definitions for the row histogram arbiter: bin geometry and arbiter FSM state.
package hog_pkg;

    localparam int NUM_BINS      = 9;
    localparam int BIN_IDX_WIDTH = 4;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/row_hist_arbiter_if.sv
// Bundle of requester, histogram-unit and downstream handshakes around the arbiter.
interface row_hist_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BIN_WIDTH  = 11,
    parameter int NUM_REQ    = 2
);
    import hog_pkg::*;

    localparam int ID_WIDTH = $clog2(NUM_REQ);

    // Every channel is valid/ready: a beat transfers on a clock edge where both
    // are high; a source keeps valid and payload stable until it is accepted.
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_magnitude;
    logic [NUM_REQ*BIN_IDX_WIDTH-1:0] req_bin;

    logic                             hu_in_valid;
    logic                             hu_in_ready;
    logic [DATA_WIDTH-1:0]            hu_magnitude;
    logic [BIN_IDX_WIDTH-1:0]         hu_bin_index;

    logic                             hu_out_valid;
    logic                             hu_out_ready;
    logic [NUM_BINS*BIN_WIDTH-1:0]    hu_histogram;

    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_BINS*BIN_WIDTH-1:0]    out_histogram;
    logic [ID_WIDTH-1:0]              out_id;

    modport slave (
        input  req_valid, req_magnitude, req_bin,
        output req_ready,
        output hu_in_valid, hu_magnitude, hu_bin_index,
        input  hu_in_ready,
        input  hu_out_valid, hu_histogram,
        output hu_out_ready,
        output out_valid, out_histogram, out_id,
        input  out_ready
    );

    modport master (
        output req_valid, req_magnitude, req_bin,
        input  req_ready,
        input  hu_in_valid, hu_magnitude, hu_bin_index,
        output hu_in_ready,
        output hu_out_valid, hu_histogram,
        input  hu_out_ready,
        input  out_valid, out_histogram, out_id,
        output out_ready
    );

endinterface

// File: rtl/row_hist_arbiter_tag_fifo.sv
// First-word-fall-through tag FIFO recording which requester owns each in-flight segment.
module tag_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/row_hist_arbiter.sv
// Round-robin arbiter sharing one row histogram unit among pixel streams, tagging results by owner.
// Optional per-requester segment counters on seg_count when ROW_HIST_ARB_STATS_EN is defined.
module row_hist_arbiter
    import hog_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int BIN_WIDTH     = 11,
    parameter  int NUM_REQ       = 2,
    parameter  int SEG_LEN       = 8,
    parameter  int ID_FIFO_DEPTH = 2,
    localparam int ID_W          = $clog2(NUM_REQ),
    localparam int CNT_W         = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1,
    localparam int FC_W          = $clog2(ID_FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    row_hist_arbiter_if.slave     bus,
    output logic                  err_orphan,
`ifdef ROW_HIST_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0] seg_count,
`endif
    output arb_state_e            o_dbg_state,
    output logic [ID_W-1:0]       o_dbg_rr_ptr,
    output logic [CNT_W-1:0]      o_dbg_beat,
    output logic [FC_W-1:0]       o_dbg_fifo_count
);

    arb_state_e               r_state;
    arb_state_e               w_state_nxt;
    logic [ID_W-1:0]          r_owner;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [CNT_W-1:0]         r_beat;
    logic                     r_err;

    logic [ID_W:0]            w_sum;
    logic [ID_W-1:0]          w_pick;
    logic                     w_found;
    logic                     w_own_valid;
    logic [DATA_WIDTH-1:0]    w_own_mag;
    logic [BIN_IDX_WIDTH-1:0] w_own_bin;
    logic                     w_hs;
    logic                     w_last;
    logic                     w_push;
    logic                     w_pop;
    logic [NUM_REQ-1:0]       w_req_ready;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [ID_W-1:0]          w_fifo_head;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            if (!w_found && bus.req_valid[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_own_valid = 1'b0;
        w_own_mag   = '0;
        w_own_bin   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == ID_W'(i)) begin
                w_own_valid = bus.req_valid[i];
                w_own_mag   = bus.req_magnitude[i*DATA_WIDTH +: DATA_WIDTH];
                w_own_bin   = bus.req_bin[i*BIN_IDX_WIDTH +: BIN_IDX_WIDTH];
            end
        end
    end

    assign w_hs   = (r_state == S_GRANT) && w_own_valid && bus.hu_in_ready;
    assign w_last = w_hs && (r_beat == CNT_W'(SEG_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_push           = 1'b0;
        w_req_ready      = '0;
        bus.hu_in_valid  = 1'b0;
        bus.hu_magnitude = '0;
        bus.hu_bin_index = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !w_fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                bus.hu_in_valid  = w_own_valid;
                bus.hu_magnitude = w_own_mag;
                bus.hu_bin_index = w_own_bin;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (r_owner == ID_W'(i)) w_req_ready[i] = bus.hu_in_ready;
                end
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_beat   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_owner <= w_pick;
            if (w_hs)   r_beat  <= w_last ? '0 : r_beat + CNT_W'(1);
            if (w_last) r_rr_ptr <= (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
            if (bus.hu_out_valid && w_fifo_empty) r_err <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (ID_FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_pick),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_dbg_fifo_count)
    );

    // A result is only forwarded when there is an owner tag to attach to it.
    assign bus.out_valid     = bus.hu_out_valid && !w_fifo_empty;
    assign bus.hu_out_ready  = bus.out_ready && !w_fifo_empty;
    assign bus.out_id        = w_fifo_head;
    assign bus.out_histogram = bus.hu_histogram;
    assign bus.req_ready     = w_req_ready;
    assign w_pop             = bus.out_valid && bus.out_ready;

    assign err_orphan   = r_err;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;
    assign o_dbg_beat   = r_beat;

`ifdef ROW_HIST_ARB_STATS_EN
    logic [15:0] r_seg_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) r_seg_cnt[i] <= '0;
        end else if (w_last) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_owner == ID_W'(i)) r_seg_cnt[i] <= r_seg_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        seg_count = '0;
        for (int i = 0; i < NUM_REQ; i++) seg_count[i*16 +: 16] = r_seg_cnt[i];
    end
`endif

endmodule

// File: tb/tb_row_hist_arbiter.sv
// Self-checking bench for row_hist_arbiter: requester sources, histogram unit model and scoreboards.
module tb_row_hist_arbiter;
    import hog_pkg::*;

    localparam int DW  = 8;
    localparam int BW  = 11;
    localparam int NR  = 2;
    localparam int SL  = 8;
    localparam int FD  = 2;
    localparam int IDW = 1;
    localparam int HW  = NUM_BINS * BW;
    localparam int PW  = IDW + DW + BIN_IDX_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_hist_arbiter_if #(.DATA_WIDTH(DW), .BIN_WIDTH(BW), .NUM_REQ(NR)) bus ();

    logic       err_orphan;
    arb_state_e dbg_state;
    logic [0:0] dbg_rr;
    logic [2:0] dbg_beat;
    logic [1:0] dbg_cnt;
`ifdef ROW_HIST_ARB_STATS_EN
    logic [NR*16-1:0] seg_count;
`endif

    row_hist_arbiter #(
        .DATA_WIDTH(DW), .BIN_WIDTH(BW), .NUM_REQ(NR), .SEG_LEN(SL), .ID_FIFO_DEPTH(FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .err_orphan       (err_orphan),
`ifdef ROW_HIST_ARB_STATS_EN
        .seg_count        (seg_count),
`endif
        .o_dbg_state      (dbg_state),
        .o_dbg_rr_ptr     (dbg_rr),
        .o_dbg_beat       (dbg_beat),
        .o_dbg_fifo_count (dbg_cnt)
    );

    // Scoreboards and source/unit models
    logic [PW-1:0]  exp_q[$];
    logic [IDW-1:0] exp_id_q[$];
    logic [HW-1:0]  exp_hist_q[$];
    logic [11:0]    src0_q[$];
    logic [11:0]    src1_q[$];
    logic [HW-1:0]  unit_q[$];
    int             start_q[$];
    logic [HW-1:0]  acc;
    logic [HW-1:0]  last_hist;
    logic [IDW-1:0] last_id;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int grant_cnt, beat_cnt, mon_beat, unit_beats;
    int hold0, drop_beat, drop_len, seg0_cnt;
    logic hu_ready_lvl, out_ready_lvl, rnd_ready, orphan_req;
    logic s_pix_hs, s_out_hs, s_hu_hs, s_hs0, s_hs1;
    logic [DW-1:0] s_mag;
    logic [3:0]    s_bin;

    initial begin
        grant_cnt = 0; beat_cnt = 0; mon_beat = 0; unit_beats = 0;
        hold0 = 0; drop_beat = -1; drop_len = 0; seg0_cnt = 0;
        hu_ready_lvl = 1'b1; out_ready_lvl = 1'b1; rnd_ready = 1'b0; orphan_req = 1'b0;
        acc = '0; last_hist = '0; last_id = '0;
        bus.req_valid = '0; bus.req_magnitude = '0; bus.req_bin = '0;
        bus.hu_in_ready = 1'b1; bus.hu_out_valid = 1'b0; bus.hu_histogram = '0;
        bus.out_ready = 1'b1;
        forever begin
            // monitor: sample just before the active edge
            @(negedge clk); #3;
            s_pix_hs = !rst && bus.hu_in_valid && bus.hu_in_ready;
            s_out_hs = !rst && bus.out_valid && bus.out_ready;
            s_hu_hs  = !rst && bus.hu_out_valid && bus.hu_out_ready;
            s_hs0    = !rst && bus.req_valid[0] && bus.req_ready[0];
            s_hs1    = !rst && bus.req_valid[1] && bus.req_ready[1];
            s_mag    = bus.hu_magnitude;
            s_bin    = bus.hu_bin_index;
            if (!rst) begin
                total++;
                if (dbg_state == S_IDLE && (bus.req_ready !== '0 || bus.hu_in_valid !== 1'b0)) begin
                    bad++;
                    $display("FAIL idle_quiet cyc=%0d req_ready=%b hu_in_valid=%b required 00/0", cyc, bus.req_ready, bus.hu_in_valid);
                end
            end
            if (s_pix_hs) begin
                logic [PW-1:0] obs;
                logic [PW-1:0] e;
                obs = {bus.req_ready[1], bus.hu_magnitude, bus.hu_bin_index};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pixel_unexpected cyc=%0d got=%h required none", cyc, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e || !$onehot(bus.req_ready)) begin
                        bad++;
                        $display("FAIL pixel cyc=%0d got=%h ready=%b required=%h", cyc, obs, bus.req_ready, e);
                    end
                end
                if (mon_beat == 0) begin
                    grant_cnt++;
                    start_q.push_back(cyc);
                end
                mon_beat = (mon_beat + 1) % SL;
                beat_cnt++;
            end
            if (s_out_hs) begin
                logic [IDW-1:0] eid;
                logic [HW-1:0]  eh;
                total++;
                last_hist = bus.out_histogram;
                last_id   = bus.out_id;
                if (exp_id_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected cyc=%0d id=%0d required none", cyc, bus.out_id);
                end else begin
                    eid = exp_id_q.pop_front();
                    eh  = exp_hist_q.pop_front();
                    if (bus.out_id !== eid || bus.out_histogram !== eh) begin
                        bad++;
                        $display("FAIL out cyc=%0d id=%0d hist=%h required id=%0d hist=%h", cyc, bus.out_id, bus.out_histogram, eid, eh);
                    end
                end
            end
            // driver: requester sources and histogram unit model
            @(posedge clk); #1;
            cyc++;
            if (hold0 > 0) hold0--;
            if (s_hs0 && src0_q.size() != 0) begin
                void'(src0_q.pop_front());
                seg0_cnt = (seg0_cnt + 1) % SL;
                if (drop_beat >= 0 && seg0_cnt == drop_beat) begin
                    hold0 = drop_len;
                    drop_beat = -1;
                end
            end
            if (s_hs1 && src1_q.size() != 0) void'(src1_q.pop_front());
            if (s_pix_hs) begin
                acc[int'(s_bin)*BW +: BW] = acc[int'(s_bin)*BW +: BW] + BW'(s_mag);
                unit_beats++;
                if (unit_beats == SL) begin
                    unit_q.push_back(acc);
                    acc = '0;
                    unit_beats = 0;
                end
            end
            if (s_hu_hs && unit_q.size() != 0) void'(unit_q.pop_front());
            bus.req_valid[0]      = (src0_q.size() != 0) && (hold0 == 0);
            bus.req_valid[1]      = (src1_q.size() != 0);
            bus.req_magnitude     = '0;
            bus.req_bin           = '0;
            if (src0_q.size() != 0) begin
                bus.req_magnitude[7:0] = src0_q[0][11:4];
                bus.req_bin[3:0]       = src0_q[0][3:0];
            end
            if (src1_q.size() != 0) begin
                bus.req_magnitude[15:8] = src1_q[0][11:4];
                bus.req_bin[7:4]        = src1_q[0][3:0];
            end
            bus.hu_in_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : hu_ready_lvl;
            bus.out_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : out_ready_lvl;
            bus.hu_out_valid = (unit_q.size() != 0) || orphan_req;
            bus.hu_histogram = (unit_q.size() != 0) ? unit_q[0] : '0;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src0_q.delete(); src1_q.delete(); unit_q.delete();
        exp_q.delete(); exp_id_q.delete(); exp_hist_q.delete(); start_q.delete();
        acc = '0; unit_beats = 0; mon_beat = 0; grant_cnt = 0; beat_cnt = 0;
        hold0 = 0; drop_beat = -1; seg0_cnt = 0;
        hu_ready_lvl = 1'b1; out_ready_lvl = 1'b1; rnd_ready = 1'b0; orphan_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Queues one segment on requester r and its expected beats and histogram (bf/mf < 0: random).
    task automatic add_seg(input int r, input int bf, input int mf);
        logic [HW-1:0] h;
        int b, m;
        h = '0;
        for (int i = 0; i < SL; i++) begin
            b = (bf < 0) ? int'($urandom_range(0, 8)) : bf;
            m = (mf < 0) ? int'($urandom_range(0, 255)) : mf;
            if (r == 0) src0_q.push_back({8'(m), 4'(b)});
            else        src1_q.push_back({8'(m), 4'(b)});
            exp_q.push_back({IDW'(r), DW'(m), 4'(b)});
            h[b*BW +: BW] = h[b*BW +: BW] + BW'(m);
        end
        exp_id_q.push_back(IDW'(r));
        exp_hist_q.push_back(h);
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_id_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || exp_id_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pixels_left=%0d results_left=%0d required 0/0", name, exp_q.size(), exp_id_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total += 6;
        if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d required=%0d", dbg_state, S_IDLE); end
        if (dbg_rr !== 1'b0) begin bad++; $display("FAIL reset_rr got=%0d required=0", dbg_rr); end
        if (dbg_cnt !== 2'd0) begin bad++; $display("FAIL reset_fifo got=%0d required=0", dbg_cnt); end
        if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_err got=%b required=0", err_orphan); end
        if (bus.req_ready !== '0 || bus.hu_in_valid !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b required 00/0", bus.req_ready, bus.hu_in_valid); end
        if (bus.out_valid !== 1'b0 || bus.hu_out_ready !== 1'b0) begin bad++; $display("FAIL reset_out got=%b/%b required 0/0", bus.out_valid, bus.hu_out_ready); end
        do_reset();
    endtask

    task automatic test_single();
        logic [HW-1:0] h;
        do_reset();
        add_seg(0, 3, 10);
        wait_drain(200, "single");
        h = '0;
        h[3*BW +: BW] = BW'(80);
        total += 3;
        if (grant_cnt !== 1) begin bad++; $display("FAIL single_grants got=%0d required=1", grant_cnt); end
        if (beat_cnt !== 8) begin bad++; $display("FAIL single_beats got=%0d required=8", beat_cnt); end
        if (last_hist !== h || last_id !== 1'b0) begin bad++; $display("FAIL single_result got id=%0d hist=%h required id=0 hist=%h", last_id, last_hist, h); end
    endtask

    task automatic test_alternate();
        do_reset();
        add_seg(0, -1, -1); add_seg(1, -1, -1); add_seg(0, -1, -1); add_seg(1, -1, -1);
        wait_drain(300, "alternate");
        total++;
        if (grant_cnt !== 4) begin bad++; $display("FAIL alternate_grants got=%0d required=4", grant_cnt); end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (start_q.size() < 4 || start_q[i] - start_q[i-1] !== SL + 1) begin
                bad++;
                $display("FAIL alternate_gap seg=%0d got=%0d required=%0d", i, (start_q.size() < 4) ? -1 : start_q[i] - start_q[i-1], SL + 1);
            end
        end
`ifdef ROW_HIST_ARB_STATS_EN
        total++;
        if (seg_count !== {16'd2, 16'd2}) begin bad++; $display("FAIL stats_count got=%h required=00020002", seg_count); end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready_lvl = 1'b0;
        add_seg(0, -1, -1); add_seg(1, -1, -1); add_seg(0, -1, -1);
        repeat (40) tick();
        total += 5;
        if (beat_cnt !== 16 || grant_cnt !== 2) begin bad++; $display("FAIL bp_beats got=%0d/%0d required 16/2", beat_cnt, grant_cnt); end
        if (dbg_cnt !== 2'd2) begin bad++; $display("FAIL bp_fifo got=%0d required=2", dbg_cnt); end
        if (dbg_state !== S_IDLE) begin bad++; $display("FAIL bp_state got=%0d required=%0d", dbg_state, S_IDLE); end
        if (bus.hu_in_valid !== 1'b0 || bus.req_ready !== '0) begin bad++; $display("FAIL bp_withheld got=%b/%b required 0/00", bus.hu_in_valid, bus.req_ready); end
        if (bus.out_valid !== 1'b1 || bus.hu_out_ready !== 1'b0) begin bad++; $display("FAIL bp_out got=%b/%b required 1/0", bus.out_valid, bus.hu_out_ready); end
        out_ready_lvl = 1'b1;
        wait_drain(200, "bp");
        total++;
        if (grant_cnt !== 3) begin bad++; $display("FAIL bp_grants got=%0d required=3", grant_cnt); end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        drop_beat = 4;
        drop_len  = 5;
        add_seg(0, -1, -1); add_seg(1, -1, -1);
        n = 0;
        while (hold0 == 0 && n < 100) begin tick(); n++; end
        total++;
        if (hold0 == 0) begin bad++; $display("FAIL stall_start got=0 required hold active"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (dbg_state !== S_GRANT || bus.req_ready[1] !== 1'b0 || bus.hu_in_valid !== 1'b0 || dbg_beat !== 3'd4) begin
                bad++;
                $display("FAIL stall_hold i=%0d state=%0d rdy1=%b hv=%b beat=%0d required 1/0/0/4", i, dbg_state, bus.req_ready[1], bus.hu_in_valid, dbg_beat);
            end
            tick();
        end
        wait_drain(200, "stall");
        total++;
        if (grant_cnt !== 2) begin bad++; $display("FAIL stall_grants got=%0d required=2", grant_cnt); end
    endtask

    task automatic test_orphan();
        do_reset();
        total++;
        if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_pre got=%b required=0", err_orphan); end
        orphan_req = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.hu_out_ready !== 1'b0) begin bad++; $display("FAIL orphan_out got=%b/%b required 0/0", bus.out_valid, bus.hu_out_ready); end
        orphan_req = 1'b0;
        tick();
        total++;
        if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_set got=%b required=1", err_orphan); end
        repeat (5) tick();
        total++;
        if (err_orphan !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL orphan_hold got=%b/%b required 1/0", err_orphan, bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        add_seg(0, -1, -1); add_seg(1, -1, -1);
        n = 0;
        while (dbg_beat !== 3'd5 && n < 100) begin tick(); n++; end
        total++;
        if (dbg_beat !== 3'd5) begin bad++; $display("FAIL rstmid_reach got=%0d required=5", dbg_beat); end
        rst = 1'b1;
        #1;
        total += 4;
        if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d required=%0d", dbg_state, S_IDLE); end
        if (bus.req_ready !== '0 || bus.hu_in_valid !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b/%b required 00/0", bus.req_ready, bus.hu_in_valid); end
        if (dbg_cnt !== 2'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_fifo got=%0d/%b required 0/0", dbg_cnt, bus.out_valid); end
        if (dbg_rr !== 1'b0 || dbg_beat !== 3'd0) begin bad++; $display("FAIL rstmid_ptr got=%0d/%0d required 0/0", dbg_rr, dbg_beat); end
        do_reset();
        add_seg(0, -1, -1); add_seg(1, -1, -1);
        wait_drain(200, "rstmid");
    endtask

    task automatic test_back_to_back();
        do_reset();
        rnd_ready = 1'b1;
        add_seg(0, -1, -1); add_seg(1, -1, -1); add_seg(0, -1, -1); add_seg(1, -1, -1);
        wait_drain(600, "b2b");
        rnd_ready = 1'b0;
        total++;
        if (grant_cnt !== 4) begin bad++; $display("FAIL b2b_grants got=%0d required=4", grant_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_stall();
        test_orphan();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
